// File: rtl/aes_encipher_block.sv
// aes_encipher_block: iterative AES encipher, one round per clock, keys from external key memory
// Ports: clk; reset (async, active-high); next/ready start/idle handshake; keylen (0=AES-128,
//        1=AES-256, sampled with next); round/round_key combinational key-memory lookup;
//        block (plaintext in); new_block (ciphertext out, valid while ready=1).
// Build option: AES_ENC_KEY256_EN honours keylen (14 rounds); undefined gives fixed 10 rounds.

module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] s
);
   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };
   assign s = SBOX[a];
endmodule

module aes_encipher_block #(
   parameter logic [3:0] AES_128_ROUNDS = 4'd10,
   parameter logic [3:0] AES_256_ROUNDS = 4'd14
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         next,
   input  logic         keylen,
   output logic [3:0]   round,
   input  logic [127:0] round_key,
   input  logic [127:0] block,
   output logic [127:0] new_block,
   output logic         ready
);
   typedef enum logic [1:0] {IDLE, INIT, MAIN, FINAL} state_t;
   state_t       fsm;
   logic [127:0] st, sb, sr, mc;
   logic [3:0]   last_round;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
   endfunction

   // xtime is linear, so 2*x ^ 3*y = xtime(x ^ y) ^ y
   function automatic logic [31:0] mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {xtime(a0 ^ a1) ^ a1 ^ a2 ^ a3,
              xtime(a1 ^ a2) ^ a0 ^ a2 ^ a3,
              xtime(a2 ^ a3) ^ a0 ^ a1 ^ a3,
              xtime(a3 ^ a0) ^ a0 ^ a1 ^ a2};
   endfunction

   // byte i sits at row i%4, column i/4; ShiftRows takes row r from column c+r
   for (genvar i = 0; i < 16; i++) begin : g_byte
      aes_sbox u_sbox (.a(st[127-8*i -: 8]), .s(sb[127-8*i -: 8]));
      assign sr[127-8*i -: 8] = sb[127-8*(4*(((i/4)+(i%4))%4)+(i%4)) -: 8];
   end
   for (genvar c = 0; c < 4; c++) begin : g_col
      assign mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
   end

`ifdef AES_ENC_KEY256_EN
   logic kl;
   assign last_round = kl ? AES_256_ROUNDS - 4'd1 : AES_128_ROUNDS - 4'd1;
`else
   logic [4:0] unused_cfg;
   assign unused_cfg = {keylen, AES_256_ROUNDS};
   assign last_round = AES_128_ROUNDS - 4'd1;
`endif

   assign new_block = st;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         fsm   <= IDLE;
         st    <= '0;
         round <= '0;
         ready <= 1'b1;
`ifdef AES_ENC_KEY256_EN
         kl    <= 1'b0;
`endif
      end else begin
         case (fsm)
            IDLE: if (next) begin
               st    <= block;
               round <= 4'd0;
               ready <= 1'b0;
               fsm   <= INIT;
`ifdef AES_ENC_KEY256_EN
               kl    <= keylen;
`endif
            end
            INIT: begin
               st    <= st ^ round_key;
               round <= 4'd1;
               fsm   <= MAIN;
            end
            MAIN: begin
               st    <= mc ^ round_key;
               round <= round + 4'd1;
               if (round == last_round) fsm <= FINAL;
            end
            FINAL: begin
               st    <= sr ^ round_key;
               ready <= 1'b1;
               fsm   <= IDLE;
            end
            default: fsm <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_aes_encipher_block.sv
// tb_aes_encipher_block: self-checking bench for aes_encipher_block (FIPS-197 vectors plus random blocks)
module tb_aes_encipher_block;
   logic         clk = 1'b0;
   logic         reset, next, keylen, ready;
   logic [3:0]   round;
   logic [127:0] round_key, block, new_block;
   logic [127:0] rk_mem [16];
   logic [7:0]   sbox_t [256];
   int           checks = 0, errors = 0;

   localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;

   aes_encipher_block dut (
      .clk(clk), .reset(reset), .next(next), .keylen(keylen), .round(round),
      .round_key(round_key), .block(block), .new_block(new_block), .ready(ready)
   );

   always #5 clk = ~clk;
   assign round_key = rk_mem[round];

   // GF(2^8) product: carry-less multiply then reduce modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p ^= 16'(a) << i;
      for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h11b << (i - 8);
      return p[7:0];
   endfunction

   // S-box from its definition: multiplicative inverse followed by the affine map
   function automatic logic [7:0] sbox_calc(input logic [7:0] a);
      logic [7:0]  inv, s;
      logic [15:0] d;
      inv = '0;
      for (int b = 1; b < 256; b++) if (a != 0 && gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
      d = {inv, inv};
      s = inv ^ 8'h63;
      for (int n = 1; n <= 4; n++) s ^= d[15-n -: 8];
      return s;
   endfunction

   function automatic logic [31:0] subword(input logic [31:0] w);
      return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
   endfunction

   task automatic expand(input logic [255:0] key, input int nk);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 60; i++) begin
         if (i < nk) w[i] = key[255-32*i -: 32];
         else begin
            t = w[i-1];
            if (i % nk == 0) begin
               t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
               rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) t = subword(t);
            w[i] = w[i-nk] ^ t;
         end
      end
      for (int r = 0; r < 15; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      rk_mem[15] = '0;
   endtask

   function automatic logic [127:0] enc(input logic [127:0] pt, input int nr);
      logic [7:0]   s [4][4];
      logic [7:0]   t [4][4];
      logic [127:0] o;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) s[r][c] = pt[127-8*(4*c+r) -: 8] ^ rk_mem[0][127-8*(4*c+r) -: 8];
      for (int k = 1; k <= nr; k++) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) t[r][c] = sbox_t[s[r][(c+r)%4]];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               s[r][c] = ((k == nr) ? t[r][c] : gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c]) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c])
                         ^ rk_mem[k][127-8*(4*c+r) -: 8];
      end
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) o[127-8*(4*c+r) -: 8] = s[r][c];
      return o;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int nr_of(input logic kl);
`ifdef AES_ENC_KEY256_EN
      return kl ? 14 : 10;
`else
      return 10;
`endif
   endfunction

   // one operation; repulse >= 0 re-asserts next (with other data) at that busy cycle
   task automatic run(input string tag, input logic [127:0] pt, input logic kl, input logic [127:0] exp, input int repulse);
      int k, nr;
      nr = nr_of(kl);
      @(negedge clk);
      block = pt; keylen = kl; next = 1'b1;
      @(negedge clk);
      next = 1'b0; block = {$urandom, $urandom, $urandom, $urandom}; keylen = 1'($urandom);
      k = 0;
      while (!ready && k < 40) begin
         chk({tag, "_round"}, 128'(round), 128'(k));
         if (k == repulse) begin
            next = 1'b1; block = ~pt;
         end else next = 1'b0;
         @(negedge clk);
         k++;
      end
      next = 1'b0;
      chk({tag, "_latency"}, 128'(k), 128'(nr + 1));
      chk({tag, "_last_round"}, 128'(round), 128'(nr));
      chk({tag, "_result"}, new_block, exp);
   endtask

   initial begin
      int k, nres, last;
      logic [255:0] key;
      logic [127:0] pt;
      logic         kl;
      for (int a = 0; a < 256; a++) sbox_t[a] = sbox_calc(8'(a));
      expand(K128, 4);
      reset = 1'b0; next = 1'b0; keylen = 1'b0; block = '0;
      #3 reset = 1'b1;
      #1;
      chk("reset_ready", 128'(ready), 128'd1);
      chk("reset_round", 128'(round), 128'd0);
      chk("reset_block", new_block, 128'd0);
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;

      run("c1", PT, 1'b0, CT1, -1);

      expand(K256, 8);
`ifdef AES_ENC_KEY256_EN
      run("c3", PT, 1'b1, CT3, -1);
`else
      run("c3_128only", PT, 1'b1, enc(PT, 10), -1);
`endif

      expand(K128, 4);
      run("repulse", PT, 1'b0, CT1, 5);

      @(negedge clk);
      block = PT; keylen = 1'b0; next = 1'b1;
      @(negedge clk);
      next = 1'b0;
      repeat (5) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("midrst_ready", 128'(ready), 128'd1);
      chk("midrst_round", 128'(round), 128'd0);
      chk("midrst_block", new_block, 128'd0);
      @(negedge clk);
      #2 reset = 1'b0;
      run("after_rst", PT, 1'b0, CT1, -1);

      @(negedge clk);
      block = PT; keylen = 1'b0; next = 1'b1;
      k = 0; nres = 0; last = 0;
      while (nres < 3 && k < 60) begin
         @(negedge clk);
         k++;
         if (ready) begin
            chk("hold_result", new_block, CT1);
            if (nres > 0) chk("hold_period", 128'(k - last), 128'd12);
            last = k; nres++;
         end
      end
      chk("hold_count", 128'(nres), 128'd3);
      next = 1'b0;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!ready && k < 40);
      chk("hold_drain", 128'(ready), 128'd1);

      for (int n = 0; n < 6; n++) begin
         for (int j = 0; j < 8; j++) key[255-32*j -: 32] = $urandom;
         pt = {$urandom, $urandom, $urandom, $urandom};
         kl = 1'($urandom);
         expand(key, kl ? 8 : 4);
         run("rand", pt, kl, enc(pt, nr_of(kl)), (n % 2 == 1) ? 3 : -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
